// File: rtl/exec_unit_pkg.sv
// Shared constants for the EX-stage execution unit: ALU control encodings,
// multiply-sequencer state encoding and the single-cycle ALU evaluation.
package exec_unit_pkg;

    // ALU control codes as produced by the ALU control decoder.
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_XOR  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0101;
    localparam logic [3:0] ALU_SRAI = 4'b0110;

    // Multiply sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Single-cycle operations. MUL is handled by the iterative datapath, so
    // it falls into the default arm here together with undefined codes.
    function automatic logic [31:0] alu_eval(
        input logic [3:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] r;
        case (op)
            ALU_AND:  r = a & b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << b[4:0];
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SRAI: r = 32'($signed(a) >>> b[4:0]);
            default:  r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exec_unit_mul_iter.sv
// Iterative shift-add multiplier datapath. A start pulse captures private
// copies of the operands; each following cycle retires BITS_PER_CYCLE
// multiplier bits until the counter runs out. The product holds afterwards.
module mul_iter #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] mcand_in,
    input  logic [31:0] mplier_in,
    output logic        last,
    output logic [31:0] product
);

    localparam int          N       = 32 / BITS_PER_CYCLE;
    localparam logic [5:0]  N_COUNT = 6'(N);

    logic [31:0] mcand_r;
    logic [31:0] mplier_r;
    logic [31:0] acc_r;
    logic [5:0]  count_r;

    // Shift-add partial product of the multiplicand with one multiplier digit.
    function automatic logic [31:0] partial_sum(
        input logic [31:0]               mcand,
        input logic [BITS_PER_CYCLE-1:0] digit
    );
        logic [31:0] sum;
        sum = 32'd0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (digit[i]) begin
                sum = sum + (mcand << i);
            end else begin
                sum = sum;
            end
        end
        return sum;
    endfunction

    // Operand capture on start, then one digit retired per cycle while counting down.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= 32'd0;
            mplier_r <= 32'd0;
            acc_r    <= 32'd0;
            count_r  <= 6'd0;
        end else if (start) begin
            mcand_r  <= mcand_in;
            mplier_r <= mplier_in;
            acc_r    <= 32'd0;
            count_r  <= N_COUNT;
        end else if (count_r != 6'd0) begin
            acc_r    <= acc_r + partial_sum(mcand_r, mplier_r[BITS_PER_CYCLE-1:0]);
            mcand_r  <= mcand_r << BITS_PER_CYCLE;
            mplier_r <= mplier_r >> BITS_PER_CYCLE;
            count_r  <= count_r - 6'd1;
        end
    end

    // The final iteration is the one executing while the counter reads 1.
    assign last    = (count_r == 6'd1);
    assign product = acc_r;

endmodule

// File: rtl/exec_unit.sv
// EX-stage execution unit: single-cycle ALU for logic/shift/add/sub and an
// iterative multiplier sequenced by a small IDLE/RUN/DONE FSM that raises
// busy_o to stall the pipeline while a multiply is in flight.
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [3:0]  ALUCtrl_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic        mem_stall_i,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        busy_o,
    output logic        done_o
);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        start_s;
    logic        mul_last_s;
    logic [31:0] mul_product_s;
    logic [31:0] alu_result_s;
    logic        is_mul_s;

    assign is_mul_s = (ALUCtrl_i == ALU_MUL);

    mul_iter #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_mul_iter (
        .clk       (clk_i),
        .rst       (rst_i),
        .start     (start_s),
        .mcand_in  (data1_i),
        .mplier_in (data2_i),
        .last      (mul_last_s),
        .product   (mul_product_s)
    );

    // Combinational single-cycle ALU result, available in the same cycle.
    always_comb begin
        alu_result_s = alu_eval(ALUCtrl_i, data1_i, data2_i);
    end

    // Sequencer state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, multiply start, stall/strobe outputs and result mux.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        result_o    = alu_result_s;
        case (state_r)
            ST_IDLE: begin
                if (valid_i && is_mul_s) begin
                    start_s     = 1'b1;
                    busy_o      = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_o = 1'b1;
                if (mul_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                // The MUL code is still on ALUCtrl_i here; it must not restart.
                done_o   = 1'b1;
                result_o = mul_product_s;
                if (mem_stall_i) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // Reset aborts any multiply and silences the handshake immediately.
        if (rst_i) begin
            start_s     = 1'b0;
            busy_o      = 1'b0;
            done_o      = 1'b0;
            state_nxt_s = ST_IDLE;
        end else begin
            start_s     = start_s;
        end
    end

    assign zero_o = (result_o == 32'd0);

endmodule

// File: tb/tb_exec_unit.sv
// Randomized self-checking bench for exec_unit: one instance at the default
// one bit per cycle, one at four bits per cycle, both checked against a
// behavioural model of results and handshake timing.
module tb_exec_unit;
    import exec_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid0, valid1;
    logic [3:0]  ctrl0, ctrl1;
    logic [31:0] a0, a1, b0, b1;
    logic        ms0, ms1;
    logic [31:0] res0, res1;
    logic        zero0, zero1, busy0, busy1, done0, done1;

    int checks;
    int failures;

    exec_unit #(.BITS_PER_CYCLE(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid0), .ALUCtrl_i(ctrl0),
        .data1_i(a0), .data2_i(b0), .mem_stall_i(ms0),
        .result_o(res0), .zero_o(zero0), .busy_o(busy0), .done_o(done0)
    );

    exec_unit #(.BITS_PER_CYCLE(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid1), .ALUCtrl_i(ctrl1),
        .data1_i(a1), .data2_i(b1), .mem_stall_i(ms1),
        .result_o(res1), .zero_o(zero1), .busy_o(busy1), .done_o(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference ALU from the operation definitions.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_AND:  r = a & b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << b[4:0];
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SRAI: r = 32'($signed(a) >>> b[4:0]);
            default:  r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic drive(input int u, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic ms);
        if (u == 0) begin
            valid0 = v; ctrl0 = op; a0 = a; b0 = b; ms0 = ms;
        end else begin
            valid1 = v; ctrl1 = op; a1 = a; b1 = b; ms1 = ms;
        end
    endtask

    task automatic sample(input int u, output logic [31:0] r, output logic z,
                          output logic bs, output logic dn);
        if (u == 0) begin
            r = res0; z = zero0; bs = busy0; dn = done0;
        end else begin
            r = res1; z = zero1; bs = busy1; dn = done1;
        end
    endtask

    // One idle-state cycle of a non-starting operation.
    task automatic alu_step(input int u, input logic v, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r, e;
        logic z, bs, dn;
        @(negedge clk);
        drive(u, v, op, a, b, 1'b0);
        #1;
        sample(u, r, z, bs, dn);
        e = ref_alu(op, a, b);
        check("alu_result", r, e);
        check("alu_zero", 32'(z), 32'(e == 32'd0));
        check("alu_busy", 32'(bs), 32'd0);
        check("alu_done", 32'(dn), 32'd0);
    endtask

    // Full multiply: start cycle, RUN cycles, then DONE held for stall extra cycles.
    task automatic mul_run(input int u, input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [31:0] r, exp_p;
        logic z, bs, dn;
        int n_busy, lat;
        exp_p = a * b;
        lat = ((u == 0) ? 32 : 8) + 1;
        @(negedge clk);
        drive(u, 1'b1, ALU_MUL, a, b, stall > 0);
        #1;
        sample(u, r, z, bs, dn);
        check("mul_busy_start", 32'(bs), 32'd1);
        n_busy = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            drive(u, 1'b1, ALU_MUL, $urandom, $urandom, stall > 0);
            #1;
            sample(u, r, z, bs, dn);
            if (!bs) break;
            n_busy++;
        end
        check("mul_busy_len", 32'(n_busy), 32'(lat));
        check("mul_done", 32'(dn), 32'd1);
        check("mul_result", r, exp_p);
        check("mul_zero", 32'(z), 32'(exp_p == 32'd0));
        for (int d = 2; d <= stall + 1; d++) begin
            @(negedge clk);
            drive(u, 1'b1, ALU_MUL, $urandom, $urandom, d <= stall);
            #1;
            sample(u, r, z, bs, dn);
            check("mul_hold_done", 32'(dn), 32'd1);
            check("mul_hold_busy", 32'(bs), 32'd0);
            check("mul_hold_result", r, exp_p);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  op;
        logic        v;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        drive(0, 1'b0, ALU_AND, 32'd0, 32'd0, 1'b0);
        drive(1, 1'b0, ALU_AND, 32'd0, 32'd0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            drive(0, 1'b1, ALU_MUL, 32'd3, 32'd3, 1'b0);
            #1;
            check("rst_busy0", 32'(busy0), 32'd0);
            check("rst_done0", 32'(done0), 32'd0);
            check("rst_busy1", 32'(busy1), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, ALU_AND, 32'd0, 32'd0, 1'b0);

        // Directed single-cycle cases.
        alu_step(0, 1'b1, ALU_ADD, 32'h7FFFFFFF, 32'd1);
        alu_step(0, 1'b1, ALU_SUB, 32'd5, 32'd5);
        alu_step(0, 1'b1, ALU_SRAI, 32'h80000000, 32'd4);
        alu_step(0, 1'b1, ALU_SLL, 32'd1, 32'd31);
        alu_step(0, 1'b1, 4'b1111, 32'h1234, 32'h5678);

        // Default-parameter multiply with MUL held through DONE.
        mul_run(0, 32'd7, 32'hFFFFFFFD, 0);
        alu_step(0, 1'b0, ALU_MUL, 32'd7, 32'hFFFFFFFD);
        alu_step(0, 1'b0, ALU_ADD, 32'd1, 32'd2);

        // Multiply with DONE held by a memory stall.
        mul_run(0, 32'h00010000, 32'h00010000, 3);
        alu_step(0, 1'b0, ALU_XOR, 32'hFF00FF00, 32'h0F0F0F0F);

        // Reset in the middle of a multiply.
        @(negedge clk);
        drive(0, 1'b1, ALU_MUL, 32'd9, 32'd9, 1'b0);
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            #1;
            check("run_busy", 32'(busy0), 32'd1);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b0, ALU_MUL, 32'd9, 32'd9, 1'b0);
        #1;
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_done", 32'(done0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        alu_step(0, 1'b1, ALU_ADD, 32'd2, 32'd3);

        // Four bits per cycle, back-to-back multiplies.
        mul_run(1, 32'd3, 32'd5, 0);
        mul_run(1, 32'h0000FFFF, 32'h0000FFFF, 0);
        alu_step(1, 1'b0, ALU_ADD, 32'd10, 32'd20);

        // Random single-cycle traffic.
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            v  = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            if (op == ALU_MUL) v = 1'b0;
            alu_step(i % 2, v, op, ra, rb);
        end

        // Random multiplies.
        for (int i = 0; i < 4; i++) begin
            ra = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            mul_run(0, ra, $urandom, $urandom_range(0, 2));
            alu_step(0, 1'b1, ALU_SUB, $urandom, $urandom);
        end
        for (int i = 0; i < 3; i++) begin
            mul_run(1, $urandom, $urandom, $urandom_range(0, 2));
            mul_run(1, $urandom, $urandom, 0);
            alu_step(1, 1'b1, ALU_AND, $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
